gpio_s2p_rx: RTL and testbench

Serial-to-parallel receiver for the GPIO serial output link: the receiving end of the 16-bit parallel-to-serial LED shifter. It samples the shift clock, serial data, clear and latch-enable lines, reassembles the word, and presents it as a latched parallel bus with a one-cycle valid strobe and frame error flag. It serves as the behavioural stand-in for the board shift-register chain in system benches, and as a loopback checker on the GPIO output path.

---
 rtl/gpio_s2p_rx_if.sv | 15 +
 rtl/gpio_s2p_rx.sv | 73 +++++++
 tb/tb_gpio_s2p_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_s2p_rx_if.sv
// gpio_s2p_rx_if: serial link lines in, latched parallel word and status out
interface gpio_s2p_rx_if #(parameter int DATA_BITS = 16);
    localparam int CW = $clog2(DATA_BITS + 2);
    logic                 sclk;
    logic                 sdin;
    logic                 sclrn;
    logic                 pen;
    logic [DATA_BITS-1:0] PData;
    logic                 valid;
    logic                 frame_err;
    logic [CW-1:0]        bit_cnt;
    logic                 busy;
    modport master(output sclk, sdin, sclrn, pen, input PData, valid, frame_err, bit_cnt, busy);
    modport slave(input sclk, sdin, sclrn, pen, output PData, valid, frame_err, bit_cnt, busy);
endinterface

// File: rtl/gpio_s2p_rx.sv
// gpio_s2p_rx: synchronizes the GPIO serial link and reassembles frames into a latched word
module gpio_s2p_rx #(
    parameter int DATA_BITS = 16,
    parameter int DIR       = 0,
    parameter int INVERT    = 1
) (
    input logic clk,
    input logic rst,
    gpio_s2p_rx_if.slave bus
);
    localparam int CW = $clog2(DATA_BITS + 2);
    typedef enum logic [1:0] {IDLE, RECV, FULL, OVER} state_t;
    state_t               st;
    logic [2:0]           sclk_s, pen_s;
    logic [1:0]           sdin_s, sclrn_s;
    logic [DATA_BITS-1:0] sh, sh_n, pd, pd_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 valid, valid_n, err, err_n, sclk_rise, pen_rise;
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s  <= '0;
            pen_s   <= '0;
            sdin_s  <= '0;
            sclrn_s <= '0;
            sh      <= '0;
            pd      <= '0;
            cnt     <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            sclk_s  <= {sclk_s[1:0], bus.sclk};
            pen_s   <= {pen_s[1:0], bus.pen};
            sdin_s  <= {sdin_s[0], bus.sdin};
            sclrn_s <= {sclrn_s[0], bus.sclrn};
            sh      <= sh_n;
            pd      <= pd_n;
            cnt     <= cnt_n;
            valid   <= valid_n;
            err     <= err_n;
        end
    end
    // pen outranks sclk, so a bit arriving with the latch edge is dropped
    always_comb begin
        sclk_rise = sclk_s[1] & ~sclk_s[2];
        pen_rise  = pen_s[1] & ~pen_s[2];
        st        = OVER;
        if (cnt == '0) st = IDLE;
        else if (cnt < CW'(DATA_BITS)) st = RECV;
        else if (cnt == CW'(DATA_BITS)) st = FULL;
        sh_n    = sh;
        pd_n    = pd;
        cnt_n   = cnt;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (!sclrn_s[1]) begin
            sh_n  = '0;
            cnt_n = '0;
        end else if (pen_rise) begin
            cnt_n   = '0;
            valid_n = st == FULL;
            err_n   = st != FULL;
            pd_n    = st == FULL ? (INVERT != 0 ? ~sh : sh) : pd;
        end else if (sclk_rise) begin
            sh_n  = DIR != 0 ? {sdin_s[1], sh[DATA_BITS-1:1]} : {sh[DATA_BITS-2:0], sdin_s[1]};
            cnt_n = st == OVER ? cnt : cnt + CW'(1);
        end
    end
    assign bus.PData     = pd;
    assign bus.valid     = valid;
    assign bus.frame_err = err;
    assign bus.bit_cnt   = cnt;
    assign bus.busy      = cnt != '0;
endmodule

// File: tb/tb_gpio_s2p_rx.sv
// tb_gpio_s2p_rx: drives one serial stream into DIR=0/INVERT=1 and DIR=1/INVERT=0 receivers against a frame-level model
module tb_gpio_s2p_rx;
    logic clk = 1'b0;
    logic rst, sclk, sdin, sclrn, pen;
    int   total = 0;
    int   bad = 0;
    bit   q[$];
    logic [15:0] e0 = '0;
    logic [15:0] e1 = '0;

    always #5 clk = ~clk;

    gpio_s2p_rx_if #(.DATA_BITS(16)) if0 ();
    gpio_s2p_rx_if #(.DATA_BITS(16)) if1 ();
    assign if0.sclk = sclk;
    assign if0.sdin = sdin;
    assign if0.sclrn = sclrn;
    assign if0.pen = pen;
    assign if1.sclk = sclk;
    assign if1.sdin = sdin;
    assign if1.sclrn = sclrn;
    assign if1.pen = pen;

    gpio_s2p_rx #(.DATA_BITS(16), .DIR(0), .INVERT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    gpio_s2p_rx #(.DATA_BITS(16), .DIR(1), .INVERT(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        sdin = b;
        sclk = 1'b0;
        tick();
        tick();
        sclk = 1'b1;
        tick();
        tick();
        sclk = 1'b0;
        q.push_back(b);
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input bit msb_first);
        for (int i = 0; i < n; i++) send_bit(msb_first ? w[n-1-i] : w[i]);
    endtask

    function automatic int exp_cnt();
        return q.size() > 17 ? 17 : q.size();
    endfunction

    task automatic check_cnt(input string tag);
        check({tag, "_cnt0"}, 32'(if0.bit_cnt), 32'(exp_cnt()));
        check({tag, "_cnt1"}, 32'(if1.bit_cnt), 32'(exp_cnt()));
        check({tag, "_busy"}, 32'(if0.busy), 32'(exp_cnt() != 0));
    endtask

    task automatic latch(input bit simul);
        logic [15:0] w0, w1;
        bit ok;
        tick();
        tick();
        check_cnt("pre");
        ok = q.size() == 16;
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                w0[15-i] = q[i];
                w1[i] = q[i];
            end
            e0 = ~w0;
            e1 = w1;
        end
        pen = 1'b1;
        if (simul) sclk = 1'b1;
        tick();
        check("early1", {28'd0, if0.valid, if0.frame_err, if1.valid, if1.frame_err}, 0);
        tick();
        check("early2", {28'd0, if0.valid, if0.frame_err, if1.valid, if1.frame_err}, 0);
        tick();
        check("valid0", 32'(if0.valid), 32'(ok));
        check("err0", 32'(if0.frame_err), 32'(!ok));
        check("valid1", 32'(if1.valid), 32'(ok));
        check("err1", 32'(if1.frame_err), 32'(!ok));
        check("pdata0", 32'(if0.PData), 32'(e0));
        check("pdata1", 32'(if1.PData), 32'(e1));
        check("post_cnt", 32'(if0.bit_cnt), 0);
        pen = 1'b0;
        sclk = 1'b0;
        tick();
        check("pulse_end", {28'd0, if0.valid, if0.frame_err, if1.valid, if1.frame_err}, 0);
        check("post_cnt2", 32'(if1.bit_cnt), 0);
        q.delete();
    endtask

    task automatic clear();
        tick();
        tick();
        check_cnt("preclr");
        sclrn = 1'b0;
        sclk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i >= 2) check("clr_cnt", 32'(if0.bit_cnt), 0);
        end
        sclrn = 1'b1;
        sclk = 1'b0;
        tick();
        tick();
        tick();
        check("clr_after", 32'(if1.bit_cnt), 0);
        q.delete();
    endtask

    initial begin
        int r, n;
        rst = 1'b1;
        sclk = 1'b0;
        sdin = 1'b0;
        sclrn = 1'b1;
        pen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sclk = ~sclk;
            pen = ~pen;
            tick();
        end
        check("rst0", {if0.PData, 11'd0, if0.valid, if0.frame_err, if0.busy, if0.bit_cnt[1:0]}, 0);
        check("rst1", {if1.PData, 11'd0, if1.valid, if1.frame_err, if1.busy, if1.bit_cnt[1:0]}, 0);
        check("rst_cnt", 32'(if0.bit_cnt), 0);
        rst = 1'b0;
        sclk = 1'b0;
        pen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rel", {28'd0, if0.valid, if0.frame_err, if1.valid, if1.frame_err}, 0);
        end
        send_word(32'hD5D5, 16, 1'b1);
        latch(1'b0);
        check("nominal", 32'(if0.PData), 32'h2A2A);
        send_word(32'h0001, 16, 1'b0);
        latch(1'b0);
        check("lsb1", 32'(if1.PData), 32'h0001);
        send_word(32'h1234, 16, 1'b0);
        latch(1'b0);
        send_word(32'hFFFF, 16, 1'b0);
        latch(1'b0);
        send_word(32'h0000, 16, 1'b0);
        latch(1'b0);
        send_word(32'h7ABC, 15, 1'b1);
        latch(1'b0);
        send_word(32'h15555, 17, 1'b1);
        latch(1'b0);
        send_word(32'hA5, 8, 1'b1);
        clear();
        send_word(32'h00FF, 16, 1'b0);
        latch(1'b0);
        check("clr_frame", 32'(if1.PData), 32'h00FF);
        send_word(32'hBEEF, 16, 1'b1);
        latch(1'b1);
        send_word(32'hCAFE, 20, 1'b1);
        latch(1'b0);
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            n = r < 6 ? 16 : r == 6 ? 15 : r == 7 ? 17 : r == 8 ? 20 : 0;
            if ($urandom_range(0, 4) == 0) begin
                send_word($urandom, int'($urandom_range(1, 12)), 1'b1);
                clear();
            end
            send_word($urandom, n, $urandom_range(0, 1) == 1);
            latch($urandom_range(0, 3) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
